// File: rtl/bus_arb_pkg.sv
// Shared encodings for the time-division bus arbiter: grant codes, phase
// indices and the SPI request FSM states.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_VIDEO = 2'd1,
    GRANT_SPI   = 2'd2,
    GRANT_CPU   = 2'd3
  } grant_e;

  localparam logic [1:0] PH_VIDEO = 2'd0;
  localparam logic [1:0] PH_SPI   = 2'd1;
  localparam logic [1:0] PH_CPU   = 2'd2;
  localparam logic [1:0] PH_IDLE  = 2'd3;

  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_WAIT   = 2'd1,
    REQ_ACTIVE = 2'd2,
    REQ_DONE   = 2'd3
  } req_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter-side bundle: SPI bridge handshake plus phase enables, grant and slot.
// The arbiter uses the slave modport; the bridge/bench side uses master.
interface bus_arbiter_if #(parameter int PHASE_BITS = 2);
  logic                  spi_pending;
  logic                  spi_strobe;
  logic                  spi_done;
  logic                  video_strobe;
  logic                  cpu_en;
  logic [1:0]            grant;
  logic [PHASE_BITS+1:0] slot;

  modport master (
    output spi_pending,
    input  spi_strobe, spi_done, video_strobe, cpu_en, grant, slot
  );

  modport slave (
    input  spi_pending,
    output spi_strobe, spi_done, video_strobe, cpu_en, grant, slot
  );
endinterface

// File: rtl/bus_arb_req.sv
// SPI bridge request FSM: IDLE -> WAIT -> ACTIVE (one full phase) -> DONE,
// with one access per pending pulse. win_start marks the last clock before a window.
module bus_arb_req
  import bus_arb_pkg::*;
#(
  parameter int PHASE_BITS = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_pending,
  input  logic win_start,
  output logic spi_strobe,
  output logic spi_done
);

  req_state_e            state, nxt;
  logic [PHASE_BITS-1:0] ph_cnt;
  logic                  ph_last;

  // Counts clocks inside the granted window so ACTIVE always spans a full phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= REQ_IDLE;
      ph_cnt <= '0;
    end else begin
      state  <= nxt;
      ph_cnt <= (state == REQ_ACTIVE) ? ph_cnt + 1'b1 : '0;
    end
  end

  assign ph_last = &ph_cnt;

  always_comb begin
    nxt = state;
    case (state)
      REQ_IDLE:   if (spi_pending) nxt = REQ_WAIT;
      REQ_WAIT: begin
        if (!spi_pending)   nxt = REQ_IDLE;
        else if (win_start) nxt = REQ_ACTIVE;
      end
      // An abort still runs the phase to completion, then skips DONE.
      REQ_ACTIVE: if (ph_last) nxt = spi_pending ? REQ_DONE : REQ_IDLE;
      REQ_DONE:   if (!spi_pending) nxt = REQ_IDLE;
      default:    nxt = REQ_IDLE;
    endcase
  end

  assign spi_strobe = (state == REQ_ACTIVE);
  assign spi_done   = (state == REQ_DONE);

endmodule

// File: rtl/bus_arbiter.sv
// Time-division bus arbiter: free-running slot counter splits each bus cycle into
// video / SPI / CPU / idle phases. BUS_ARB_IDLE_STEAL_EN lets SPI also use the idle phase.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int PHASE_BITS = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  bus_arbiter_if.slave       bus
);

  localparam int CW = PHASE_BITS + 2;

  logic [CW-1:0]         cnt;
  logic [1:0]            phase;
  logic [PHASE_BITS-1:0] low;
  logic                  low_last;
  logic                  win_start;
  logic                  spi_strobe;
  logic                  spi_done;
  grant_e                grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + 1'b1;
  end

  assign phase    = cnt[CW-1 -: 2];
  assign low      = cnt[PHASE_BITS-1:0];
  assign low_last = &low;

  // Fires on the clock before a grantable window so only whole phases are granted.
`ifdef BUS_ARB_IDLE_STEAL_EN
  assign win_start = low_last && (phase == PH_VIDEO || phase == PH_CPU);
`else
  assign win_start = low_last && (phase == PH_VIDEO);
`endif

  bus_arb_req #(.PHASE_BITS(PHASE_BITS)) u_req (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_pending(bus.spi_pending),
    .win_start  (win_start),
    .spi_strobe (spi_strobe),
    .spi_done   (spi_done)
  );

  always_comb begin
    grant = GRANT_IDLE;
    case (phase)
      PH_VIDEO: grant = GRANT_VIDEO;
      PH_SPI:   if (spi_strobe) grant = GRANT_SPI;
      PH_CPU:   grant = GRANT_CPU;
`ifdef BUS_ARB_IDLE_STEAL_EN
      PH_IDLE:  if (spi_strobe) grant = GRANT_SPI;
`endif
      default:  grant = GRANT_IDLE;
    endcase
  end

  assign bus.spi_strobe   = spi_strobe;
  assign bus.spi_done     = spi_done;
  assign bus.video_strobe = (phase == PH_VIDEO);
  assign bus.cpu_en       = (phase == PH_CPU) && low_last;
  assign bus.grant        = grant;
  assign bus.slot         = cnt;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes per-cycle expectations built
// from hand-derived strobe/done windows; a negedge monitor pops and compares.
module tb_bus_arbiter;
  localparam int PB = 2;
  localparam int SW = PB + 2;
  localparam int NS = 1 << SW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.PHASE_BITS(PB)) bus();
  bus_arbiter #(.PHASE_BITS(PB)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct {
    string         tag;
    int            k;
    logic [SW-1:0] slot;
    logic          vs, ss, sd, ce;
    logic [1:0]    gr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int k, input string f,
                     input logic [7:0] act, input logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s k=%0d %s: got %0h want %0h", tag, k, f, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, e.k, "slot",         8'(bus.slot),         8'(e.slot));
      chk(e.tag, e.k, "video_strobe", 8'(bus.video_strobe), 8'(e.vs));
      chk(e.tag, e.k, "spi_strobe",   8'(bus.spi_strobe),   8'(e.ss));
      chk(e.tag, e.k, "spi_done",     8'(bus.spi_done),     8'(e.sd));
      chk(e.tag, e.k, "cpu_en",       8'(bus.cpu_en),       8'(e.ce));
      chk(e.tag, e.k, "grant",        8'(bus.grant),        8'(e.gr));
    end
  end

  task automatic do_reset();
    bus.spi_pending = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Cycle k = clocks since reset release; pending is high for rise <= k < fall.
  // Expected strobe/done windows are given directly in k; rst_at pulses reset for one cycle.
  task automatic run_scn(input string tag, input int rise, input int fall,
                         input int s_lo, input int s_hi, input int d_lo, input int d_hi,
                         input int rst_at, input int ncyc);
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      exp_t e;
      int   sl;
      int   ph;
      logic in_rst;
      bus.spi_pending = (k >= rise && k < fall);
      in_rst  = (k == rst_at);
      reset_n = !in_rst;
      if (in_rst)                      sl = 0;
      else if (rst_at >= 0 && k > rst_at) sl = (k - rst_at - 1) % NS;
      else                             sl = k % NS;
      ph     = sl >> PB;
      e.tag  = tag;
      e.k    = k;
      e.slot = SW'(sl);
      e.ss   = !in_rst && k >= s_lo && k <= s_hi;
      e.sd   = !in_rst && k >= d_lo && k <= d_hi;
      e.vs   = (ph == 0);
      e.ce   = (sl == 11);
      e.gr   = (ph == 0) ? 2'd1 : (ph == 2) ? 2'd3 : e.ss ? 2'd2 : 2'd0;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.spi_pending = 1'b0;
    run_scn("quiet",     0,    0,  1,  0,  1,    0,   -1, 32);
    run_scn("req_at1",   1,   10,  4,  7,  8,   10,   -1, 40);
    run_scn("req_at2",   2,   12,  4,  7,  8,   12,   -1, 24);
`ifdef BUS_ARB_IDLE_STEAL_EN
    run_scn("req_at3",   3,   26, 12, 15, 16,   26,   -1, 40);
`else
    run_scn("req_at3",   3,   26, 20, 23, 24,   26,   -1, 40);
`endif
    run_scn("abort",     1,    5,  4,  7,  1,    0,   -1, 24);
    run_scn("held",      1, 1000,  4,  7,  8, 1000,   -1, 56);
    run_scn("mid_reset", 1,    6,  4,  5,  1,    0,    6, 24);
    repeat (4) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Time-division arbiter for the shared system RAM/IO bus. A free-running slot counter splits every bus cycle into fixed phases: video fetch, bridge (SPI) access, CPU access and idle. It emits the phase enables and grant, and runs the level-based pending/strobe/done handshake that lets the asynchronous SPI bridge claim its phase.

## Interface
Parameters:
- `PHASE_BITS`, default 2: log2 of clocks per phase; bus cycle = 4 × 2^PHASE_BITS clocks (16 by default).

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `spi_pending`  in  1  level; bridge requests one bus access; deassertion ends or cancels it.
- `spi_strobe`  out  1  high for the whole granted SPI phase; the bridge drives the bus while it is high.
- `spi_done`  out  1  high from the end of the granted phase until `spi_pending` falls.
- `video_strobe`  out  1  high for the whole video phase.
- `cpu_en`  out  1  one-clock pulse on the last clock of the CPU phase; advances the CPU one bus cycle.
- `grant`  out  2  current bus owner: 0 IDLE, 1 VIDEO, 2 SPI, 3 CPU.
- `slot`  out  PHASE_BITS+2  current counter value; top 2 bits are the phase index.

## Operation
- Counter: PHASE_BITS+2 bits, increments every clock and wraps from all-ones to 0.
- Phase decode from counter[top:top-1]:
  - 0 = VIDEO
  - 1 = SPI
  - 2 = CPU
  - 3 = IDLE
- `video_strobe` equals phase==0. `grant`=VIDEO in that phase.
- `cpu_en` equals (phase==2 && low bits all-ones). `grant`=CPU for the whole CPU phase.
- SPI request FSM states: IDLE, WAIT, ACTIVE, DONE.
  - IDLE→WAIT: on an edge where `spi_pending`=1.
  - WAIT→ACTIVE: on the edge where counter = last clock of phase 0.
  - ACTIVE→DONE: on the edge where counter = last clock of the SPI phase, if `spi_pending`=1.
  - ACTIVE→IDLE: on that same edge, if `spi_pending`=0. The access is aborted, but the phase is never cut short and `spi_done` is not raised.
  - WAIT or DONE → IDLE: on any edge where `spi_pending`=0.
  - DONE holds until `spi_pending` falls, so there is exactly one access per pending pulse.
- `spi_strobe` = state==ACTIVE. `grant`=SPI when ACTIVE. If no access is granted in the SPI phase, `grant`=IDLE.
- A request that arrives during or after the SPI phase waits for the next cycle; partial phases are never granted.
- All outputs are decoded from registered state only; there are no combinational paths from input to output.
- Reset (asserted at any time, including mid-phase): counter=0, FSM=IDLE.
  - During and immediately after reset: `spi_strobe`=0, `spi_done`=0, `cpu_en`=0.
  - `video_strobe` is high during reset (counter 0 is the video phase), and `grant`=VIDEO.
  - An in-flight SPI access is dropped.

## Timing
Default PHASE_BITS=2.
- Counter ranges per phase: video 0–3, SPI 4–7, CPU 8–11, idle 12–15.
- `cpu_en` is high at counter 11.
- Request timing:
  - `spi_pending` first sampled high at counter ≤2: WAIT by counter 3, ACTIVE at counters 4–7, `spi_done` from counter 8.
  - First sampled at counter 3: waits a full cycle, ACTIVE at counters 20–23 (mod 16).
  - Best-case latency from pending to strobe: 2 clocks. Worst case: 17 clocks.
- Request rate:
  - The bridge must drop `spi_pending` after `spi_done` before requesting again.
  - Re-asserting in the clock after IDLE is observed is legal.
  - Maximum rate is one access per bus cycle.

## Configuration
`BUS_ARB_IDLE_STEAL_EN`:
- Defined:
  - A WAIT request can also be granted in phase 3. WAIT→ACTIVE additionally occurs at the edge at counter = last clock of the CPU phase.
  - ACTIVE→DONE (or →IDLE on abort) occurs at the end of phase 3 for an idle-phase grant, as for the SPI phase.
  - The SPI phase grant has priority because it occurs earlier in the cycle.
  - Worst-case latency drops to 9 clocks.
- Undefined: phase 3 is always `grant`=IDLE and `spi_strobe`=0.

## Structure
- Package `bus_arb_pkg` holds:
  - grant encodings (GRANT_IDLE/VIDEO/SPI/CPU)
  - phase indices
  - the request FSM state enum.
- Sub-module `bus_arb_req`: the SPI pending/strobe/done FSM. Inputs are `spi_pending` and a one-clock "grant window starts next clock" pulse from the counter decode.

## Test plan
- Reset release: for 32 clocks, `video_strobe` is high at counters 0–3 and 16–19, `cpu_en` pulses only at counters 11 and 27, and `spi_strobe` stays 0 with `spi_pending` low.
- `spi_pending` raised at counter 1 → `spi_strobe` high at counters 4–7, `grant`=2, `spi_done` from counter 8. Drop pending at counter 10 → `spi_done`=0 at counter 11.
- `spi_pending` raised at counter 3 → `spi_strobe` high at counters 20–23. With `BUS_ARB_IDLE_STEAL_EN` defined → `spi_strobe` high at counters 12–15 instead.
- `spi_pending` dropped at counter 5 → `spi_strobe` stays high through counter 7, then state IDLE. `spi_done` never asserts.
- `spi_pending` held high through a completed access → `spi_done` stays 1 and no second strobe occurs across 3 bus cycles.
- `reset_n` pulsed low at counter 6 during an SPI access → `spi_strobe`=0 immediately. After release: counter=0, `video_strobe`=1, `spi_done`=0.
